// File: rtl/bk_sequencer.sv
`default_nettype none
// =============================================================================
// bk_sequencer : backup-RAM load/save sequencer on the hps_io sector handshake
// Rev 1.0
// =============================================================================
module bk_sequencer #(
   parameter int SECTORS = 128,
   parameter int TIMEOUT = 50000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        bk_ena,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        autosave,
   input  logic        dl_active,
   input  logic        bram_we,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        busy,
   output logic        loading,
   output logic        dirty,
   output logic        done,
   output logic        err
);

   localparam int               LBA_W    = (SECTORS > 2) ? $clog2(SECTORS) : 1;
   localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);
   localparam logic [26:0]      CNT_LAST = 27'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK = 2'd1;
   localparam logic [1:0] ST_WAIT_END = 2'd2;
   localparam logic [1:0] ST_ABORT    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LBA_W-1:0] lba_q, lba_d;
   logic [26:0]      cnt_q, cnt_d;
   logic             rd_q, rd_d, wr_q, wr_d;
   logic             busy_q, busy_d, loading_q, loading_d;
   logic             dirty_q, dirty_d, done_q, done_d, err_q, err_d;
   logic             wflag_q, wflag_d;
   logic             load_prev_q, save_prev_q, auto_prev_q, dl_prev_q, ack_prev_q;

   logic load_rise, save_rise, auto_rise, dl_rise, dl_fall, ack_rise, ack_fall;
   logic start_load, start_save, cnt_expired, last_sector;

   assign load_rise   = load_req & ~load_prev_q;
   assign save_rise   = save_req & ~save_prev_q;
   assign auto_rise   = autosave & ~auto_prev_q;
   assign dl_rise     = dl_active & ~dl_prev_q;
   assign dl_fall     = ~dl_active & dl_prev_q;
   assign ack_rise    = sd_ack & ~ack_prev_q;
   assign ack_fall    = ~sd_ack & ack_prev_q;
   assign start_load  = bk_ena & (load_rise | dl_fall);
   assign start_save  = bk_ena & ~start_load & (save_rise | (auto_rise & dirty_q));
   assign cnt_expired = (cnt_q == CNT_LAST);
   assign last_sector = (lba_q == LBA_LAST);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lba_q       <= '0;
         cnt_q       <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         loading_q   <= 1'b0;
         dirty_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wflag_q     <= 1'b0;
         load_prev_q <= 1'b0;
         save_prev_q <= 1'b0;
         auto_prev_q <= 1'b0;
         dl_prev_q   <= 1'b0;
         ack_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lba_q       <= lba_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
         loading_q   <= loading_d;
         dirty_q     <= dirty_d;
         done_q      <= done_d;
         err_q       <= err_d;
         wflag_q     <= wflag_d;
         load_prev_q <= load_req;
         save_prev_q <= save_req;
         auto_prev_q <= autosave;
         dl_prev_q   <= dl_active;
         ack_prev_q  <= sd_ack;
      end
   end

   always_comb begin
      state_d = state_q;
      if (dl_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     if (start_load || start_save) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack_rise) state_d = ST_WAIT_END;
                         else if (cnt_expired) state_d = ST_ABORT;
            ST_WAIT_END: if (ack_fall) state_d = last_sector ? ST_IDLE : ST_WAIT_ACK;
                         else if (cnt_expired) state_d = ST_ABORT;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Register next values; loading_q distinguishes a load from a save mid-transfer.
   always_comb begin
      lba_d     = lba_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      busy_d    = busy_q;
      loading_d = loading_q;
      dirty_d   = dirty_q | (bram_we & ~loading_q);
      wflag_d   = wflag_q | (bram_we & ~loading_q);
      done_d    = 1'b0;
      err_d     = 1'b0;
      cnt_d     = cnt_q + 27'd1;
      if (dl_rise) begin
         rd_d      = 1'b0;
         wr_d      = 1'b0;
         busy_d    = 1'b0;
         loading_d = 1'b0;
         err_d     = busy_q;
         dirty_d   = 1'b0;
         cnt_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (start_load) begin
                  lba_d     = '0;
                  rd_d      = 1'b1;
                  loading_d = 1'b1;
                  busy_d    = 1'b1;
               end else if (start_save) begin
                  lba_d   = '0;
                  wr_d    = 1'b1;
                  busy_d  = 1'b1;
                  wflag_d = bram_we;
               end
            end
            ST_WAIT_ACK, ST_WAIT_END: begin
               if (state_q == ST_WAIT_ACK && ack_rise) begin
                  rd_d  = 1'b0;
                  wr_d  = 1'b0;
                  cnt_d = '0;
               end else if (state_q == ST_WAIT_END && ack_fall) begin
                  cnt_d = '0;
                  if (last_sector) begin
                     done_d    = 1'b1;
                     busy_d    = 1'b0;
                     loading_d = 1'b0;
                     dirty_d   = loading_q ? 1'b0 : (wflag_q | bram_we);
                  end else begin
                     lba_d = lba_q + LBA_W'(1);
                     rd_d  = loading_q;
                     wr_d  = ~loading_q;
                  end
               end else if (cnt_expired) begin
                  rd_d      = 1'b0;
                  wr_d      = 1'b0;
                  busy_d    = 1'b0;
                  loading_d = 1'b0;
                  err_d     = 1'b1;
               end
            end
            default: cnt_d = '0;
         endcase
      end
   end

   always_comb begin
      sd_lba  = 32'(lba_q);
      sd_rd   = rd_q;
      sd_wr   = wr_q;
      busy    = busy_q;
      loading = loading_q;
      dirty   = dirty_q;
      done    = done_q;
      err     = err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_bk_sequencer.sv
`default_nettype none
// =============================================================================
// tb_bk_sequencer : scoreboard bench for bk_sequencer with a randomised sd_ack
// responder. Rev 1.0
// =============================================================================
module tb_bk_sequencer;

   localparam int SECTORS = 128;
   localparam int TIMEOUT = 100;
   localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

   logic        clk, reset, bk_ena, load_req, save_req, autosave, dl_active, bram_we, sd_ack;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, busy, loading, dirty, done, err;

   bk_sequencer #(.SECTORS(SECTORS), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys(clk), .reset(reset), .bk_ena(bk_ena), .load_req(load_req),
      .save_req(save_req), .autosave(autosave), .dl_active(dl_active),
      .bram_we(bram_we), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
      .sd_wr(sd_wr), .busy(busy), .loading(loading), .dirty(dirty),
      .done(done), .err(err)
   );

   typedef struct { int kind; int lba; } ev_t;
   ev_t exp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, rd_cyc = 0, err_cyc = 0, loading_bad = 0;
   int ack_en = 1, stall_lba = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sb_event(input int kind, input int lba);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got kind=%0d lba=%0d expected no event", kind, lba);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (e.lba >= 0 && e.lba != lba)) begin
            errors++;
            $display("FAIL sb_event: got kind=%0d lba=%0d expected kind=%0d lba=%0d",
                     kind, lba, e.kind, e.lba);
         end
      end
   endtask

   // Reference: a transfer issues one request per sector 0..last, then done.
   task automatic push_xfer(input bit is_load, input int last, input bit with_done);
      for (int i = 0; i <= last; i++) exp_q.push_back('{is_load ? K_RD : K_WR, i});
      if (with_done) exp_q.push_back('{K_DONE, -1});
   endtask

   task automatic drain(input string nm, input int budget, input int mode);
      int  n = 0;
      bit  fired = 0;
      while (exp_q.size() != 0 && n < budget) begin
         bram_we = 1'b0;
         if (mode == 1) bram_we = loading & ($urandom_range(0, 3) == 0);
         if (mode == 2 && !fired && sd_wr && sd_lba == 32'd10) begin
            bram_we = 1'b1;
            fired   = 1;
         end
         @(negedge clk);
         n++;
      end
      bram_we = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d events outstanding expected 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_req(input string nm, input int lba, input int budget);
      int n = 0;
      while (!((sd_rd || sd_wr) && sd_lba == 32'(lba)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(n < budget), 64'd1);
   endtask

   task automatic idle_window(input string nm, input int n);
      int busy_seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (busy || sd_rd || sd_wr) busy_seen++;
      end
      chk(nm, 64'(busy_seen), 64'd0);
   endtask

   // sd_ack responder: random latency and ack width, long hold at stall_lba.
   initial begin : responder
      int wait_cnt = 0, hold_cnt = 0;
      sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_en == 0 || reset) begin
            sd_ack = 1'b0; wait_cnt = 0; hold_cnt = 0;
         end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) sd_ack = 1'b0;
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               sd_ack   = 1'b1;
               hold_cnt = (int'(sd_lba) == stall_lba) ? 200 : int'($urandom_range(1, 6));
            end
         end else if ((sd_rd || sd_wr) && !sd_ack) begin
            wait_cnt = int'($urandom_range(1, 4));
         end
      end
   end

   initial begin : monitor
      logic prev_rd = 1'b0, prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (sd_rd && !prev_rd) begin rd_cyc = cyc; sb_event(K_RD, int'(sd_lba)); end
         if (sd_wr && !prev_wr) sb_event(K_WR, int'(sd_lba));
         if (done) sb_event(K_DONE, int'(sd_lba));
         if (err) begin err_cyc = cyc; sb_event(K_ERR, int'(sd_lba)); end
         if (sd_rd && !loading) loading_bad++;
         prev_rd = sd_rd;
         prev_wr = sd_wr;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1'b1; bk_ena = 1'b0; load_req = 1'b0; save_req = 1'b0; autosave = 1'b0;
      dl_active = 1'b0; bram_we = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_lba", 64'(sd_lba), 64'd0);
      chk("rst_ctl", 64'({sd_rd, sd_wr, busy, loading, dirty, done, err}), 64'd0);
      reset = 1'b0; bk_ena = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_ctl", 64'({sd_rd, sd_wr, busy, loading, dirty, done, err}), 64'd0);

      // Load with random hps_io bram_we traffic; dirty from before is cleared.
      bram_we = 1'b1; @(negedge clk); bram_we = 1'b0;
      chk("dirty_set", 64'(dirty), 64'd1);
      push_xfer(1, SECTORS - 1, 1);
      load_req = 1'b1; @(negedge clk); load_req = 1'b0;
      drain("load_drain", 6000, 1);
      chk("load_dirty", 64'(dirty), 64'd0);
      chk("load_flags", 64'({busy, loading}), 64'd0);
      chk("load_loading_flag", 64'(loading_bad), 64'd0);

      // Save with a core write at sector 10 keeps dirty; autosave then clears it.
      repeat ($urandom_range(2, 8)) @(negedge clk);
      bram_we = 1'b1; @(negedge clk); bram_we = 1'b0;
      push_xfer(0, SECTORS - 1, 1);
      save_req = 1'b1; @(negedge clk); save_req = 1'b0;
      drain("save_drain", 6000, 2);
      chk("save_dirty_kept", 64'(dirty), 64'd1);
      push_xfer(0, SECTORS - 1, 1);
      autosave = 1'b1; @(negedge clk); autosave = 1'b0;
      drain("autosave_drain", 6000, 0);
      chk("autosave_dirty", 64'(dirty), 64'd0);

      // Autosave while clean does nothing.
      autosave = 1'b1;
      idle_window("autosave_clean_busy", 20);
      autosave = 1'b0;

      // Simultaneous load and save edges: load only.
      push_xfer(1, SECTORS - 1, 1);
      load_req = 1'b1; save_req = 1'b1; @(negedge clk);
      chk("merge_rd_wr", 64'({sd_rd, sd_wr}), 64'b10);
      load_req = 1'b0; save_req = 1'b0;
      drain("merge_drain", 6000, 0);

      // End of ROM download triggers auto-load the next cycle.
      dl_active = 1'b1; repeat (5) @(negedge clk);
      push_xfer(1, SECTORS - 1, 1);
      dl_active = 1'b0; @(negedge clk);
      chk("autoload_next", 64'(sd_rd), 64'd1);
      drain("autoload_drain", 6000, 0);
      bk_ena = 1'b0;
      dl_active = 1'b1; repeat (3) @(negedge clk); dl_active = 1'b0;
      idle_window("autoload_disabled", 20);
      bk_ena = 1'b1;

      // No acknowledge: abort after TIMEOUT cycles.
      ack_en = 0;
      exp_q.push_back('{K_RD, 0});
      exp_q.push_back('{K_ERR, 0});
      load_req = 1'b1; @(negedge clk); load_req = 1'b0;
      drain("timeout_drain", 400, 0);
      chk("timeout_cycles", 64'(err_cyc - rd_cyc), 64'(TIMEOUT));
      chk("timeout_state", 64'({busy, loading, sd_rd}), 64'd0);
      chk("timeout_lba", 64'(sd_lba), 64'd0);
      ack_en = 1;
      repeat (3) @(negedge clk);

      // Ack stuck high at sector 5.
      stall_lba = 5;
      push_xfer(1, 5, 0);
      exp_q.push_back('{K_ERR, 5});
      load_req = 1'b1; @(negedge clk); load_req = 1'b0;
      drain("stall_drain", 2000, 0);
      chk("stall_lba", 64'(sd_lba), 64'd5);
      chk("stall_state", 64'({busy, loading}), 64'd0);
      repeat (220) @(negedge clk);
      stall_lba = -1;

      // Download restart in the middle of a load.
      bram_we = 1'b1; @(negedge clk); bram_we = 1'b0;
      push_xfer(1, 20, 0);
      exp_q.push_back('{K_ERR, 20});
      load_req = 1'b1; @(negedge clk); load_req = 1'b0;
      wait_req("dl_wait_lba20", 20, 3000);
      dl_active = 1'b1;
      drain("dl_abort_drain", 20, 0);
      chk("dl_abort_state", 64'({loading, busy, dirty}), 64'd0);
      repeat (20) @(negedge clk);
      push_xfer(1, SECTORS - 1, 1);
      dl_active = 1'b0; @(negedge clk);
      chk("dl_autoload_next", 64'(sd_rd), 64'd1);
      drain("dl_autoload_drain", 6000, 0);

      // Asynchronous reset mid-save at sector 40.
      push_xfer(0, 40, 0);
      save_req = 1'b1; @(negedge clk); save_req = 1'b0;
      wait_req("rst_wait_lba40", 40, 3000);
      #2 reset = 1'b1;
      #1;
      chk("midrst_lba", 64'(sd_lba), 64'd0);
      chk("midrst_ctl", 64'({sd_rd, sd_wr, busy, loading, dirty, done, err}), 64'd0);
      chk("midrst_sb", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk); reset = 1'b0;
      idle_window("post_midrst_idle", 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
